// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key encoder.
//   - assembler FSM state encoding
//   - prefix bytes (E0 extended, E1 pause, F0 release)
//   - fake-shift codes that extended sequences wrap around some keys
//   - keyboard status bytes that are never key events (drop list)
//   - number of bytes swallowed after an E1 prefix (rest of Pause)
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_REL     = 3'd2,
    ST_EXT_REL = 3'd3,
    ST_SKIP    = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] PFX_REL   = 8'hF0;

  localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // ACK, self-test pass, echo, resend, buffer overrun/error codes.
  function automatic logic is_drop(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: PS/2 frame receiver.
//   clk_sys, reset          : system clock, async active-high reset
//   ps2_clk, ps2_data       : raw asynchronous PS/2 lines
//   byte_valid / byte_data  : one-cycle strobe with the received byte
//   frame_err               : one-cycle pulse on start/parity/stop/timeout error
module ps2_rx_byte #(
  parameter int FILTER         = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int HW = 2 * FILTER;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HW-1:0] FALL_PAT = {{FILTER{1'b1}}, {FILTER{1'b0}}};
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic [HW-1:0] hist_q, hist_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          fall;

  // Idle PS/2 lines are high; resetting the synchronizers high keeps the
  // history from seeing a phantom falling edge right after reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      hist_q      <= '1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      hist_q      <= hist_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // Newest sample enters at bit 0; an edge needs FILTER highs then FILTER lows.
  assign fall   = (hist_q == FALL_PAT);
  assign hist_d = {hist_q[HW-2:0], clk_sync_q};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: begin
          if (data_sync_q) err_d = 1'b1;
          else             bit_cnt_d = 4'd1;
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        4'd9: begin
          par_d     = data_sync_q;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (!data_sync_q || !(^{shift_q, par_q})) err_d   = 1'b1;
          else                                      valid_d = 1'b1;
        end
        default: bit_cnt_d = 4'd0;
      endcase
    end else if (bit_cnt_q == 4'd0) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      err_d     = 1'b1;
      bit_cnt_d = 4'd0;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard stream to 11-bit toggle key events.
//   clk_sys, reset      : system clock, async active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 lines
//   ps2_key[10]         : toggles on every event
//   ps2_key[9]          : pressed
//   ps2_key[8]          : extended
//   ps2_key[7:0]        : scan code
//   frame_err           : one-cycle pulse on any dropped frame
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, next byte is an extended make code or F0
// ST_REL     | F0 seen, next byte is a released code
// ST_EXT_REL | E0 F0 seen, next byte is an extended released code
// ST_SKIP    | swallowing the remainder of the Pause sequence
module ps2_key_encoder #(
  parameter int FILTER         = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  import ps2_pkg::*;

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  ps2_state_e  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [10:0] key_q, key_d;
  logic        ferr_q;
  logic        emit;
  logic [9:0]  emit_word;

  ps2_rx_byte #(
    .FILTER        (FILTER),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_err)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      key_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      key_q   <= key_d;
      ferr_q  <= rx_err;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == PFX_EXT)        state_d = ST_EXT;
          else if (rx_byte == PFX_REL)   state_d = ST_REL;
          else if (rx_byte == PFX_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end
        end
        ST_EXT:     state_d = (rx_byte == PFX_REL) ? ST_EXT_REL : ST_IDLE;
        ST_REL:     state_d = ST_IDLE;
        ST_EXT_REL: state_d = ST_IDLE;
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_word = {1'b1, 1'b0, rx_byte};
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          emit = (rx_byte != PFX_EXT) && (rx_byte != PFX_REL) &&
                 (rx_byte != PFX_PAUSE) && !is_drop(rx_byte);
        end
        ST_EXT: begin
          emit      = (rx_byte != PFX_REL) && !is_fake_shift(rx_byte);
          emit_word = {1'b1, 1'b1, rx_byte};
        end
        ST_REL: begin
          emit      = 1'b1;
          emit_word = {1'b0, 1'b0, rx_byte};
        end
        ST_EXT_REL: begin
          emit      = !is_fake_shift(rx_byte);
          emit_word = {1'b0, 1'b1, rx_byte};
        end
        default: emit = 1'b0;
      endcase
    end
    key_d = emit ? {~key_q[10], emit_word} : key_q;
  end

  assign ps2_key   = key_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder. The PS/2 clock is scaled up
// (80 system cycles per bit) and the timeout shortened to keep runtime small.
module tb_ps2_key_encoder;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 500;
  localparam int HALF    = 40;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  typedef struct packed {
    logic        is_err;
    logic [10:0] key;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk   = 0;
  int          n_fail  = 0;
  logic        exp_tog = 1'b0;
  logic [10:0] prev_key = '0;
  logic [10:0] hold_key;

  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder #(
    .FILTER        (FILTER),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every key change or error pulse consumes one expectation.
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_key = '0;
    end else begin
      if (ps2_key !== prev_key) begin
        if (sb_q.size() == 0) begin
          check("unexpected_key", 32'(ps2_key), 32'(prev_key));
        end else begin
          mon_e = sb_q.pop_front();
          check("event_kind", 32'(frame_err), 32'(mon_e.is_err));
          check("ps2_key", 32'(ps2_key), 32'(mon_e.key));
        end
        prev_key = ps2_key;
      end
      if (frame_err) begin
        if (sb_q.size() == 0) begin
          check("unexpected_err", 32'(frame_err), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("err_kind", 32'(frame_err), 32'(mon_e.is_err));
        end
      end
    end
  end

  task automatic push_key(input logic p, input logic e, input logic [7:0] code);
    exp_t x;
    exp_tog  = ~exp_tog;
    x.is_err = 1'b0;
    x.key    = {exp_tog, p, e, code};
    sb_q.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x.is_err = 1'b1;
    x.key    = '0;
    sb_q.push_back(x);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF / 2) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk_sys);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(posedge clk_sys);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    ps2_data = 1'b1;
    repeat (3 * HALF) @(posedge clk_sys);
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 4000) begin
      @(posedge clk_sys);
      n++;
    end
    check(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] pause_seq [10];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hE0, 8'h12};

    repeat (10) @(posedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    repeat (20) @(posedge clk_sys);

    // simple press
    push_key(1'b1, 1'b0, 8'h1C);
    send(8'h1C);
    drain("press_1c");

    // extended release: only one event for three bytes
    push_key(1'b0, 1'b1, 8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    drain("ext_rel_75");

    // parity error leaves ps2_key alone, next good frame decodes
    hold_key = ps2_key;
    push_err();
    send_bits(8'h23, 1'b1, 11);
    drain("parity_err");
    check("parity_key_hold", 32'(ps2_key), 32'(hold_key));
    push_key(1'b1, 1'b0, 8'h23);
    send(8'h23);
    drain("press_23");

    // timeout after 5 bits
    push_err();
    send_bits(8'h1C, 1'b0, 5);
    repeat (TIMEOUT + 50) @(posedge clk_sys);
    drain("timeout_err");
    push_key(1'b1, 1'b0, 8'h1C);
    send(8'h1C);
    drain("after_timeout");

    // Pause swallowed, fake shift dropped, then a normal press
    foreach (pause_seq[i]) send(pause_seq[i]);
    push_key(1'b1, 1'b0, 8'h29);
    send(8'h29);
    drain("after_pause");

    // status byte dropped, plain release
    push_key(1'b0, 1'b0, 8'h1C);
    send(8'hFA);
    send(8'hF0);
    send(8'h1C);
    drain("rel_1c");

    // short clock glitch must not start a frame
    ps2_clk = 1'b0;
    repeat (2) @(posedge clk_sys);
    ps2_clk = 1'b1;
    repeat (50) @(posedge clk_sys);
    push_key(1'b1, 1'b0, 8'h16);
    send(8'h16);
    drain("after_glitch");

    // reset with pending E0 and a partial frame discards everything
    send(8'hE0);
    send_bits(8'h5A, 1'b0, 6);
    reset = 1'b1;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    check("midreset_key", 32'(ps2_key), 32'd0);
    check("midreset_err", 32'(frame_err), 32'd0);
    exp_tog = 1'b0;
    @(posedge clk_sys);
    reset = 1'b0;
    repeat (20) @(posedge clk_sys);
    push_key(1'b1, 1'b0, 8'h1C);
    send(8'h1C);
    drain("after_reset");

    repeat (50) @(posedge clk_sys);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
